// File: rtl/uart_cmd_parser_pkg.sv
// Shared constants and types for the UART-to-SD command parser and the SD CRC7 helper.
// Also holds the SD command frame field positions.
package uart_cmd_parser_pkg;

  localparam logic [7:0] SD_SYNC_BYTE = 8'hA5;
  localparam logic [6:0] CRC7_POLY    = 7'h09;   // x^7 + x^3 + 1

  localparam int FRAME_W   = 48;
  localparam int IDX_MSB   = 45;
  localparam int IDX_LSB   = 40;
  localparam int ARG_MSB   = 39;
  localparam int ARG_LSB   = 8;
  localparam int CRC_MSB   = 7;
  localparam int CRC_LSB   = 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_ARG  = 2'd2
  } state_t;

endpackage

// File: rtl/uart_cmd_parser_crc7.sv
// Combinational SD CRC7 update over one byte, MSB first.
// Shared with the SD command transmitter.
module sd_crc7_byte
  import uart_cmd_parser_pkg::*;
(
  input  logic [6:0] crc_in,
  input  logic [7:0] data,
  output logic [6:0] crc_out
);

  logic [6:0] crc;
  logic       fb;

  always_comb begin
    crc = crc_in;
    fb  = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      fb  = crc[6] ^ data[i];
      crc = {crc[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
    end
    crc_out = crc;
  end

endmodule

// File: rtl/uart_cmd_parser.sv
// Assembles sync/command/4-argument byte frames from the UART rx register into
// 48-bit SD command tokens and offers them to the command-line sequencer.
module uart_cmd_parser
  import uart_cmd_parser_pkg::*;
#(
  parameter logic [7:0]  SYNC_BYTE = SD_SYNC_BYTE,
  parameter logic [15:0] TIMEOUT   = 16'd4096
) (
  input  logic               ex_clk,
  input  logic               reset,
  input  logic [7:0]         rx_data_out,
  input  logic               rx_contains_data,
  input  logic               cmd_ready,
  output logic               cmd_valid,
  output logic [FRAME_W-1:0] cmd_frame,
  output logic               busy,
  output logic               err_format,
  output logic               err_timeout,
  output logic               err_overflow,
  output state_t             dbg_state
);

  // Handshake: a frame transfers on any edge where cmd_valid & cmd_ready;
  // cmd_frame is held stable while cmd_valid & ~cmd_ready.

  state_t               state_q, state_n;
  logic [1:0]           cnt_q, cnt_n;
  logic [5:0]           index_q, index_n;
  logic [31:0]          arg_q, arg_n;
  logic [6:0]           crc_q, crc_n, crc_in, crc_out;
  logic [15:0]          tmo_q, tmo_n;
  logic                 flag_d;
  logic                 valid_n;
  logic [FRAME_W-1:0]   frame_n, new_frame;
  logic                 fmt_n, tmo_hit_n, ovf_n;
  logic                 byte_stb, tmo_hit, complete;

  assign byte_stb  = rx_contains_data & ~flag_d;
  assign tmo_hit   = (tmo_q == TIMEOUT);
  assign crc_in    = (state_q == ST_CMD) ? 7'h00 : crc_q;
  assign new_frame = {2'b01, index_q, arg_q[23:0], rx_data_out, crc_out, 1'b1};
  assign busy      = (state_q != ST_IDLE);
  assign dbg_state = state_q;

  sd_crc7_byte u_crc (
    .crc_in  (crc_in),
    .data    (rx_data_out),
    .crc_out (crc_out)
  );

  always_comb begin
    state_n   = state_q;
    cnt_n     = cnt_q;
    index_n   = index_q;
    arg_n     = arg_q;
    crc_n     = crc_q;
    valid_n   = cmd_valid;
    frame_n   = cmd_frame;
    fmt_n     = 1'b0;
    tmo_hit_n = 1'b0;
    ovf_n     = 1'b0;
    complete  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (byte_stb && rx_data_out == SYNC_BYTE) state_n = ST_CMD;
      end
      ST_CMD: begin
        if (byte_stb) begin
          if (rx_data_out[7:6] == 2'b01) begin
            index_n = rx_data_out[5:0];
            crc_n   = crc_out;
            cnt_n   = 2'd0;
            state_n = ST_ARG;
          end else begin
            fmt_n   = 1'b1;
            state_n = ST_IDLE;
          end
        end else if (tmo_hit) begin
          tmo_hit_n = 1'b1;
          state_n   = ST_IDLE;
        end
      end
      ST_ARG: begin
        if (byte_stb) begin
          arg_n = {arg_q[23:0], rx_data_out};
          crc_n = crc_out;
          if (cnt_q == 2'd3) begin
            complete = 1'b1;
            state_n  = ST_IDLE;
          end else begin
            cnt_n = cnt_q + 2'd1;
          end
        end else if (tmo_hit) begin
          tmo_hit_n = 1'b1;
          state_n   = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase

    // A completing frame may replace one that is being consumed this cycle.
    if (complete && (!cmd_valid || cmd_ready)) begin
      frame_n = new_frame;
      valid_n = 1'b1;
    end else if (complete) begin
      ovf_n = 1'b1;
    end else if (cmd_valid && cmd_ready) begin
      valid_n = 1'b0;
    end

    if (state_q == ST_IDLE || byte_stb || tmo_hit) tmo_n = 16'd0;
    else                                            tmo_n = tmo_q + 16'd1;
  end

  always_ff @(posedge ex_clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 2'd0;
      index_q      <= 6'd0;
      arg_q        <= 32'd0;
      crc_q        <= 7'd0;
      tmo_q        <= 16'd0;
      flag_d       <= 1'b0;
      cmd_valid    <= 1'b0;
      cmd_frame    <= '0;
      err_format   <= 1'b0;
      err_timeout  <= 1'b0;
      err_overflow <= 1'b0;
    end else begin
      state_q      <= state_n;
      cnt_q        <= cnt_n;
      index_q      <= index_n;
      arg_q        <= arg_n;
      crc_q        <= crc_n;
      tmo_q        <= tmo_n;
      flag_d       <= rx_contains_data;
      cmd_valid    <= valid_n;
      cmd_frame    <= frame_n;
      err_format   <= fmt_n;
      err_timeout  <= tmo_hit_n;
      err_overflow <= ovf_n;
    end
  end

endmodule
